// File: rtl/keypad_reader_pkg.sv
// Shared types and constants for the scanned 4x4 keypad reader.
// Holds the FSM state enum, the key code type and the keypad geometry.
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {
    SCAN,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } state_t;

  typedef logic [3:0] key_code_t;

  // Index of the lowest-numbered row pulled low; 0 when none are low.
  function automatic logic [1:0] first_low_row(input logic [NUM_ROWS-1:0] row_bits);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = NUM_ROWS; i > 0; i--) begin
      if (!row_bits[i-1]) idx = 2'(i - 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_reader_sync2.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
// Reset value is a parameter so idle (pulled-up) lines read as inactive.
module sync2
  import keypad_pkg::*;
#(
  parameter int unsigned          WIDTH     = NUM_ROWS,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_reader.sv
// Scanned 4x4 keypad reader: column scan, press/release debounce, 8-digit hex entry.
// Define KEYPAD_READER_AUTOREPEAT_EN to re-accept a held key every REPEAT_CYCLES clocks.
module keypad_reader
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_BITS       = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_CYCLES   = 5000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_ROWS-1:0] rows,
  output logic [NUM_COLS-1:0] cols,
  input  logic                clear,
  output key_code_t           key_code,
  output logic                key_valid,
  output logic [31:0]         value
);

  localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned CNT_W = (SCAN_BITS > DB_W) ? SCAN_BITS : DB_W;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((64'd1 << SCAN_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_READER_AUTOREPEAT_EN
  localparam int unsigned RPT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
  logic [RPT_W-1:0] r_rpt;
`endif

  state_t              r_state;
  logic [1:0]          r_col;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_ROWS-1:0] r_pat;
  logic [NUM_COLS-1:0] r_cols;
  key_code_t           r_key_code;
  logic                r_key_valid;
  logic [31:0]         r_value;

  logic [NUM_ROWS-1:0] w_rows;
  logic                w_any_low;
  key_code_t           w_code;

  sync2 #(
    .WIDTH     (NUM_ROWS),
    .RESET_VAL ('1)
  ) u_sync (
    .i_clk   (clock),
    .i_rst_n (resetn),
    .i_d     (rows),
    .o_q     (w_rows)
  );

  assign w_any_low = ~&w_rows;
  assign w_code    = {first_low_row(r_pat), r_col};

  // Column drive trails r_col by one clock, so each column is shown for a full dwell.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= SCAN;
      r_col       <= '0;
      r_cnt       <= '0;
      r_pat       <= '1;
      r_cols      <= '1;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_value     <= '0;
`ifdef KEYPAD_READER_AUTOREPEAT_EN
      r_rpt       <= '0;
`endif
    end else begin
      r_cols      <= ~(NUM_COLS'(1) << r_col);
      r_key_valid <= 1'b0;
      if (clear) r_value <= '0;

      unique case (r_state)
        SCAN: begin
          if (r_cnt == DWELL_LAST) begin
            r_cnt <= '0;
            if (w_any_low) begin
              r_state <= PRESS_DB;
              r_pat   <= w_rows;
            end else begin
              r_col <= r_col + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        PRESS_DB: begin
          if (w_rows != r_pat) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_col   <= r_col + 2'd1;
          end else if (r_cnt == DB_LAST) begin
            r_state     <= HELD;
            r_cnt       <= '0;
            r_key_valid <= 1'b1;
            r_key_code  <= w_code;
            r_value     <= clear ? '0 : {r_value[27:0], w_code};
`ifdef KEYPAD_READER_AUTOREPEAT_EN
            r_rpt       <= '0;
`endif
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        HELD: begin
          if (!w_any_low) begin
            r_state <= RELEASE_DB;
            r_cnt   <= '0;
          end
`ifdef KEYPAD_READER_AUTOREPEAT_EN
          // Repeat timer only pauses through a release bounce; it restarts on a fresh press.
          else if (r_rpt == RPT_LAST) begin
            r_rpt       <= '0;
            r_key_valid <= 1'b1;
            r_value     <= clear ? '0 : {r_value[27:0], r_key_code};
          end else begin
            r_rpt <= r_rpt + RPT_W'(1);
          end
`endif
        end

        RELEASE_DB: begin
          if (w_any_low) begin
            r_state <= HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state <= SCAN;
            r_cnt   <= '0;
            r_col   <= r_col + 2'd1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign cols      = r_cols;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign value     = r_value;

endmodule

// File: tb/tb_keypad_reader.sv
// Self-checking bench for keypad_reader: timeline model over synchronized-row history,
// directed scenarios plus randomized key activity (honours KEYPAD_READER_AUTOREPEAT_EN).
module tb_keypad_reader;

  localparam int unsigned SB = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RP = 16;
  localparam int DWELL = 1 << SB;
  localparam logic [3:0] IDLE = 4'hF;

  localparam int M_SCAN    = 0;
  localparam int M_CONFIRM = 1;
  localparam int M_DOWN    = 2;
  localparam int M_UP      = 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [31:0] value;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  int pulses = 0;

  always #5 clock = ~clock;

  // Key index equals its code: bit {row,col}. A key pulls its row low while its column is driven.
  always_comb begin
    rows = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  keypad_reader #(
    .SCAN_BITS       (SB),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .rows      (rows),
    .cols      (cols),
    .clear     (clear),
    .key_code  (key_code),
    .key_valid (key_valid),
    .value     (value)
  );

  // Model: edge count since reset, raw row samples per edge, phase start times.
  int          t;
  logic [3:0]  raw [0:255];
  int          mode, base, c0, s, u, kcol, rpt_acc;
  logic [3:0]  pat;
  logic [3:0]  m_cols, m_kc;
  logic        m_kv;
  logic [31:0] m_val;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timed out time=%0t", nm, $time);
  endfunction

  function automatic logic [3:0] syn(input int tt);
    return (tt <= 2) ? IDLE : raw[(tt - 2) % 256];
  endfunction

  function automatic int low_row(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (!p[i]) return i;
    return 0;
  endfunction

  function automatic int col_now();
    return (mode == M_SCAN) ? (c0 + (t - base) / DWELL) % 4 : kcol;
  endfunction

  function automatic void model_reset();
    t = 0; mode = M_SCAN; base = 0; c0 = 0; kcol = 0; s = 0; u = 0; rpt_acc = 0;
    pat = IDLE; m_cols = IDLE; m_kv = 1'b0; m_kc = '0; m_val = '0;
  endfunction

  function automatic void model_step(input logic [3:0] r_in, input logic clr);
    int cb;
    logic [3:0] d, acode;
    logic acc;
    cb = col_now();
    t++;
    raw[t % 256] = r_in;
    d = syn(t);
    m_cols = ~(4'b0001 << cb);
    acc = 1'b0;
    acode = '0;
    case (mode)
      M_SCAN:
        if ((t - base) % DWELL == 0 && d != IDLE) begin
          kcol = (c0 + (t - base) / DWELL - 1) % 4;
          mode = M_CONFIRM; s = t; pat = d;
        end
      M_CONFIRM:
        if (d != pat) begin
          mode = M_SCAN; base = t; c0 = (kcol + 1) % 4;
        end else if (t - s == DB) begin
          acc = 1'b1; acode = 4'(low_row(pat) * 4 + kcol);
          mode = M_DOWN; rpt_acc = 0;
        end
      M_DOWN:
        if (d == IDLE) begin
          mode = M_UP; u = t;
        end else begin
`ifdef KEYPAD_READER_AUTOREPEAT_EN
          rpt_acc++;
          if (rpt_acc == RP) begin acc = 1'b1; acode = m_kc; rpt_acc = 0; end
`endif
        end
      default:
        if (d != IDLE) mode = M_DOWN;
        else if (t - u == DB) begin mode = M_SCAN; base = t; c0 = (kcol + 1) % 4; end
    endcase
    m_kv = acc;
    if (acc) begin
      m_kc = acode;
      m_val = clr ? 32'h0 : {m_val[27:0], acode};
    end else if (clr) begin
      m_val = 32'h0;
    end
  endfunction

  // One clock: model consumes this cycle's inputs, then DUT outputs are compared at negedge.
  task automatic tick();
    #1;
    model_step(rows, clear);
    @(posedge clock);
    @(negedge clock);
    check("cols", 32'(cols), 32'(m_cols));
    check("key_valid", 32'(key_valid), 32'(m_kv));
    check("key_code", 32'(key_code), 32'(m_kc));
    check("value", value, m_val);
    if (key_valid) pulses++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    tick();
    while (!m_kv && n < 80) begin tick(); n++; end
    if (!m_kv) fail_timeout(nm);
    else check(nm, 32'(key_valid), 32'd1);
  endtask

  task automatic wait_cols(input logic [3:0] target);
    int n;
    n = 0;
    while (m_cols == target && n < 64) begin tick(); n++; end
    while (m_cols != target && n < 64) begin tick(); n++; end
    if (m_cols != target) fail_timeout("wait_cols");
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_cols"}, 32'(cols), 32'hF);
    check({nm, "_kv"}, 32'(key_valid), 32'h0);
    check({nm, "_code"}, 32'(key_code), 32'h0);
    check({nm, "_value"}, value, 32'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] scan_pat [0:3];
    int p0, n;
    scan_pat[0] = 4'b1110; scan_pat[1] = 4'b1101;
    scan_pat[2] = 4'b1011; scan_pat[3] = 4'b0111;

    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    resetn = 1'b1;

    // Idle scan: each column low for one full dwell, in order.
    for (int i = 1; i <= 16; i++) begin
      tick();
      check("idle_scan_cols", 32'(cols), 32'(scan_pat[((i - 1) / DWELL) % 4]));
      check("idle_kv", 32'(key_valid), 32'h0);
    end

    // Row 2 pressed while column 2 is driven.
    wait_cols(4'b1011);
    p0 = pulses;
    keys[4'hA] = 1'b1;
    ticks(20);
    keys = '0;
    ticks(20);
    check("single_key_pulses", 32'(pulses - p0), 32'd1);
    check("single_key_code", 32'(key_code), 32'hA);
    check("single_key_value", value, 32'h0000000A);

    clear = 1'b1; tick(); clear = 1'b0;
    check("clear_value", value, 32'h0);

    // Keys 1..9: the first digit falls off the top.
    for (int k = 1; k <= 9; k++) begin
      keys = '0;
      keys[k] = 1'b1;
      wait_accept("nine_accept");
      ticks(3);
      keys = '0;
      ticks(16);
    end
    check("nine_value", value, 32'h23456789);

    // Two-clock glitch on column 1 must not produce a key.
    wait_cols(4'b1101);
    p0 = pulses;
    keys[4'h1] = 1'b1;
    ticks(2);
    keys = '0;
    ticks(12);
    check("glitch_pulses", 32'(pulses - p0), 32'd0);

    // Release bounce inside the release debounce window.
    p0 = pulses;
    keys[4'h6] = 1'b1;
    wait_accept("bounce_accept");
    ticks(3);
    keys = '0;
    ticks(3);
    keys[4'h6] = 1'b1;
    ticks(2);
    keys = '0;
    ticks(16);
    check("bounce_pulses", 32'(pulses - p0), 32'd1);

    // clear held through the acceptance clock.
    clear = 1'b1;
    keys[4'hC] = 1'b1;
    n = 0;
    tick();
    while (!m_kv && n < 80) begin tick(); n++; end
    if (!m_kv) fail_timeout("clear_accept");
    else begin
      check("clear_accept_kv", 32'(key_valid), 32'd1);
      check("clear_accept_value", value, 32'h0);
      check("clear_accept_code", 32'(key_code), 32'hC);
    end
    clear = 1'b0;
    keys = '0;
    ticks(16);

    // Long hold of key 5.
    clear = 1'b1; tick(); clear = 1'b0;
    p0 = pulses;
    keys[4'h5] = 1'b1;
    wait_accept("hold_accept");
    ticks(40);
    keys = '0;
    ticks(16);
`ifdef KEYPAD_READER_AUTOREPEAT_EN
    check("hold_pulses", 32'(pulses - p0), 32'd3);
    check("hold_value", value, 32'h00000555);
`else
    check("hold_pulses", 32'(pulses - p0), 32'd1);
    check("hold_value", value, 32'h00000005);
`endif

    // Reset asserted mid press-debounce.
    keys[4'hF] = 1'b1;
    n = 0;
    while (!(mode == M_CONFIRM && t - s == 2) && n < 80) begin tick(); n++; end
    if (!(mode == M_CONFIRM && t - s == 2)) fail_timeout("reach_press_db");
    #2 resetn = 1'b0;
    #1 check_reset_outputs("mid_db_reset");
    keys = '0;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    p0 = pulses;
    ticks(40);
    check("after_reset_pulses", 32'(pulses - p0), 32'd0);
    check("after_reset_value", value, 32'h0);

    // Randomized key activity.
    for (int it = 0; it < 250; it++) begin
      int nk, hold;
      nk = $urandom_range(0, 2);
      keys = '0;
      for (int j = 0; j < nk; j++) keys[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 30);
      for (int h = 0; h < hold; h++) begin
        clear = ($urandom_range(0, 15) == 0);
        tick();
      end
      clear = 1'b0;
    end
    keys = '0;
    ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
